// File: rtl/alpha_data_emulator_pkg.sv
// Shared ALPHA definitions: word width, default header word, emulator states
// and the data-word parity helper. alpha_readout uses the same header
// constant, so both ends of the loopback agree on frame alignment.
package alpha_data_emulator_pkg;

    localparam int ALPHA_WORD_WIDTH = 16;

    // Frame header sent ahead of every burst of data words.
    localparam logic [ALPHA_WORD_WIDTH-1:0] ALPHA_HEADER = 16'hA1FA;

    // ST_ prefix keeps the state names apart from the HEADER parameter.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_GAP    = 2'd3
    } alpha_state_e;

    // Even parity: the XOR of all bits of the word.
    function automatic logic word_parity(input logic [ALPHA_WORD_WIDTH-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/alpha_word_serializer.sv
// 16-bit load/shift register, MSB first, with a bit counter and a last-bit strobe.
// Ports: clk_i/rst_i (sync, active high); load_i/word_i/ext_i load a word,
//   optionally followed by its parity bit; shift_i advances one bit;
//   msb_o is the registered serial bit; last_bit_o marks the word's final bit.
module alpha_word_serializer
    import alpha_data_emulator_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  logic                        ext_i,
    input  logic                        shift_i,
    input  logic [ALPHA_WORD_WIDTH-1:0] word_i,
    output logic                        msb_o,
    output logic                        last_bit_o
);

    // One spare LSB holds the parity bit of an extended word. For a plain
    // word it is 0, so the bit that follows the final data bit is already a
    // low idle bit.
    localparam int SW = ALPHA_WORD_WIDTH + 1;

    logic [SW-1:0] shreg_q;
    logic [4:0]    bit_cnt_q;
    logic          ext_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            ext_q     <= 1'b0;
        end else if (load_i) begin
            shreg_q   <= {word_i, ext_i & word_parity(word_i)};
            bit_cnt_q <= '0;
            ext_q     <= ext_i;
        end else if (shift_i) begin
            shreg_q   <= {shreg_q[SW-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 5'd1;
        end
    end

    assign msb_o      = shreg_q[SW-1];
    assign last_bit_o = ext_q ? (bit_cnt_q == 5'd16) : (bit_cnt_q == 5'd15);

endmodule

// File: rtl/alpha_data_emulator.sv
// Emulates the ALPHA data_a stream: HEADER, then WORDS_PER_FRAME data words
// (MSB first, one bit per clock), then GAP_CYCLES low cycles and a frame_done pulse.
// Ports: clock/reset (sync, active high); start; word_in/word_valid/word_ready
//   handshake; data_a serial out; busy, frame_done, sticky underflow, words_sent.
// Optional: define ALPHA_DATA_EMULATOR_PARITY_EN to append an even-parity bit
//   after every data word (not the header); word_ready then moves to that bit.
module alpha_data_emulator
    import alpha_data_emulator_pkg::*;
#(
    parameter logic [ALPHA_WORD_WIDTH-1:0] HEADER          = ALPHA_HEADER,
    parameter int                          WORDS_PER_FRAME = 8,
    parameter int                          GAP_CYCLES      = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ALPHA_WORD_WIDTH-1:0] word_in,
    input  logic                        word_valid,
    output logic                        word_ready,
    output logic                        data_a,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        underflow,
    output logic [7:0]                  words_sent
);

`ifdef ALPHA_DATA_EMULATOR_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_FRAME);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    alpha_state_e state_q;
    logic [7:0]   gap_cnt_q;      // gap cycles remaining after the current one
    logic [7:0]   words_sent_q;
    logic         underflow_q;
    logic         busy_q;
    logic         frame_done_q;

    logic                        accept;
    logic                        final_word;
    logic                        ser_load;
    logic                        ser_ext;
    logic                        ser_shift;
    logic                        ser_msb;
    logic                        ser_last;
    logic [ALPHA_WORD_WIDTH-1:0] ser_word;

    // words_sent already counts the word on the wire, so equality with
    // WORDS_PER_FRAME means the final data word is being sent.
    assign final_word = (words_sent_q == LAST_WORD);
    assign accept     = (state_q == ST_IDLE) && start;
    assign word_ready = ser_last &&
                        ((state_q == ST_HEADER) || ((state_q == ST_DATA) && !final_word));

    // The next word is loaded on the same edge that retires the last bit of
    // the current one, so words follow each other with no bubble. A missing
    // word goes out as all zeros.
    assign ser_load  = accept || word_ready;
    assign ser_ext   = !accept && PARITY_EN;
    assign ser_word  = accept ? HEADER : (word_valid ? word_in : '0);
    assign ser_shift = (state_q == ST_HEADER) || (state_q == ST_DATA);

    alpha_word_serializer u_ser (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (ser_load),
        .ext_i      (ser_ext),
        .shift_i    (ser_shift),
        .word_i     (ser_word),
        .msb_o      (ser_msb),
        .last_bit_o (ser_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            words_sent_q <= '0;
            underflow_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    frame_done_q <= 1'b0;
                    if (start) begin
                        state_q      <= ST_HEADER;
                        busy_q       <= 1'b1;
                        underflow_q  <= 1'b0;
                        words_sent_q <= '0;
                    end
                end
                ST_HEADER, ST_DATA: begin
                    if (ser_last) begin
                        if ((state_q == ST_DATA) && final_word) begin
                            state_q      <= ST_GAP;
                            gap_cnt_q    <= GAP_LAST;
                            // A single-cycle gap is its own final cycle.
                            frame_done_q <= (GAP_LAST == 8'd0);
                        end else begin
                            state_q      <= ST_DATA;
                            words_sent_q <= words_sent_q + 8'd1;
                            if (!word_valid) begin
                                underflow_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 8'd0) begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b0;
                    end else begin
                        gap_cnt_q    <= gap_cnt_q - 8'd1;
                        frame_done_q <= (gap_cnt_q == 8'd1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_a     = ser_msb;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underflow  = underflow_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_alpha_data_emulator.sv
module tb_alpha_data_emulator;

    localparam int WPF = 2;
    localparam int GAP = 4;
`ifdef ALPHA_DATA_EMULATOR_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int WL = 16 + P;               // cycles per data word
    localparam int L  = 16 + WL * WPF + GAP;  // 52 without parity
    localparam logic [15:0] HDR = 16'hA1FA;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        data_a;
    logic        busy;
    logic        frame_done;
    logic        underflow;
    logic [7:0]  words_sent;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    alpha_data_emulator #(
        .HEADER          (HDR),
        .WORDS_PER_FRAME (WPF),
        .GAP_CYCLES      (GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .data_a     (data_a),
        .busy       (busy),
        .frame_done (frame_done),
        .underflow  (underflow),
        .words_sent (words_sent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Expected serial bit in frame cycle c (1 = first header bit).
    function automatic logic exp_bit(input int c, input logic [15:0] w0, input logic [15:0] w1);
        logic [15:0] w;
        int d, wi, b;
        if (c <= 16) return HDR[16 - c];
        d  = c - 17;
        wi = d / WL;
        b  = d % WL;
        if (wi >= WPF) return 1'b0;
        w = (wi == 0) ? w0 : w1;
        if (b < 16) return w[15 - b];
        return ^w;
    endfunction

    // Sends one frame; v1 = word_valid for the second word, poke = extra start
    // pulses at cycle 10 and in the frame_done cycle.
    task automatic run_frame(input string nm, input logic [15:0] w0, input logic [15:0] w1,
                             input bit v1, input bit poke, input bit exp_uf);
        logic [15:0] w1e;
        logic        took;
        logic        exp_rdy;
        w1e        = v1 ? w1 : 16'h0000;
        word_in    = w0;
        word_valid = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= L; c++) begin
            exp_rdy = (c == 16) ||
                      ((c > 16) && (c <= 16 + WL * (WPF - 1)) && ((c - 16) % WL == 0));
            chk($sformatf("%s data_a c%0d", nm, c), 32'(data_a), 32'(exp_bit(c, w0, w1e)));
            chk($sformatf("%s busy c%0d", nm, c), 32'(busy), 32'd1);
            chk($sformatf("%s frame_done c%0d", nm, c), 32'(frame_done), 32'(c == L));
            chk($sformatf("%s word_ready c%0d", nm, c), 32'(word_ready), 32'(exp_rdy));
            if (c == 1) begin
                chk({nm, " underflow cleared"}, 32'(underflow), 32'd0);
                chk({nm, " words_sent cleared"}, 32'(words_sent), 32'd0);
            end
            if (c == 17)      chk({nm, " words_sent w1"}, 32'(words_sent), 32'd1);
            if (c == 17 + WL) chk({nm, " words_sent w2"}, 32'(words_sent), 32'd2);
            took  = word_ready && word_valid;
            start = poke && ((c == 10) || (c == L));
            tick();
            if (took) begin
                word_in    = w1;
                word_valid = v1;
            end
        end
        start = 1'b0;
        chk({nm, " busy after"}, 32'(busy), 32'd0);
        chk({nm, " frame_done after"}, 32'(frame_done), 32'd0);
        chk({nm, " data_a after"}, 32'(data_a), 32'd0);
        chk({nm, " words_sent after"}, 32'(words_sent), 32'd2);
        chk({nm, " underflow after"}, 32'(underflow), 32'(exp_uf));
        tick();
        tick();
        chk({nm, " no restart"}, 32'(busy), 32'd0);
        chk({nm, " data_a idle"}, 32'(data_a), 32'd0);
        chk({nm, " underflow held"}, 32'(underflow), 32'(exp_uf));
        chk({nm, " words_sent held"}, 32'(words_sent), 32'd2);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        word_valid = 1'b0;
        word_in    = 16'h0000;
        tick();
        tick();
        chk("rst data_a", 32'(data_a), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("rst underflow", 32'(underflow), 32'd0);
        chk("rst words_sent", 32'(words_sent), 32'd0);
        chk("rst word_ready", 32'(word_ready), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle busy", 32'(busy), 32'd0);

        run_frame("basic", 16'h1234, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        run_frame("uflow", 16'hCAFE, 16'h5555, 1'b0, 1'b0, 1'b1);
        run_frame("poke", 16'h1234, 16'hBEEF, 1'b1, 1'b1, 1'b0);

        // Reset during bit 5 of the first data word (frame cycle 22).
        word_in    = 16'h1234;
        word_valid = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 22; c++) tick();
        chk("mid bit5", 32'(data_a), 32'(exp_bit(22, 16'h1234, 16'h1234)));
        chk("mid busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst data_a", 32'(data_a), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst frame_done", 32'(frame_done), 32'd0);
        chk("midrst words_sent", 32'(words_sent), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("midrst quiet frame_done", 32'(frame_done), 32'd0);
            chk("midrst quiet data_a", 32'(data_a), 32'd0);
        end

        run_frame("parity", 16'h0001, 16'h0003, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alpha_data_emulator.md
Name: alpha_data_emulator

Overview:
- Serial transmitter that emulates the ALPHA ASIC's data_a output stream: a 16-bit header word, then WORDS_PER_FRAME 16-bit data words, all MSB first, one bit per clock.
- Drives the receive path (alpha_readout) in FPGA-internal loopback, or drives a coax pin into a second board when no ASIC is fitted.
- Data words come from an upstream source through a valid/ready handshake.

Parameters:
- HEADER, 16'hA1FA, header word sent at the start of every frame.
- WORDS_PER_FRAME, 8, data words per frame (1..255).
- GAP_CYCLES, 16, idle-low cycles after the last data bit, before frame_done (1..255).

Ports:
- clock  in  1  system clock (sysclk domain); one serial bit per cycle.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request to send one frame; ignored while busy=1.
- word_in  in  16  next data word.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  a word is taken on any cycle where word_valid and word_ready are both high.
- data_a  out  1  registered serial output; idle low.
- busy  out  1  high from the cycle after start is accepted until the frame_done cycle, inclusive.
- frame_done  out  1  one-cycle pulse at the end of the gap.
- underflow  out  1  sticky flag; set when a word was needed but word_valid was low; cleared by reset or an accepted start.
- words_sent  out  8  data words sent in the current or last frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register and counters 0.
- Reset asserted mid-frame: on the next edge, data_a=0, state=IDLE, and no frame_done.
- States: IDLE -> HEADER -> DATA -> GAP -> IDLE.
- IDLE:
  - start=1 sampled at edge k: shift register loads HEADER, bit_cnt=0, underflow=0, words_sent=0, and state becomes HEADER.
  - data_a=HEADER[15] from edge k+1; busy=1 from edge k+1.
- HEADER/DATA: each edge shifts the register left one bit; data_a always shows the register MSB, held registered. Each word lasts exactly 16 cycles.
- word_ready:
  - Combinational. High only in the cycle when the last bit (bit_cnt=15) of the header or of a non-final data word is on data_a.
  - Low in IDLE and GAP, and during the final data word.
- Word load at the end of each of those cycles:
  - If word_valid: load word_in.
  - Otherwise: load 16'h0000 and set underflow.
  - Either way, the word counts toward words_sent, and there are no bubbles between words.
- words_sent increments on the edge where a data word starts transmitting. It wraps at 256, which is unreachable with a legal WORDS_PER_FRAME, and holds its value after the frame.
- After 16 bits of data word number WORDS_PER_FRAME: state becomes GAP, data_a=0 for GAP_CYCLES cycles.
- On the final GAP cycle, frame_done=1. busy falls on the next edge, and state returns to IDLE.
- Frame length from first header bit to frame_done, inclusive: 16 + 16*WORDS_PER_FRAME + GAP_CYCLES cycles.
- start while busy is dropped, with no queueing.
- start in the same cycle that frame_done is high is also dropped; the next frame needs a start while busy=0.
- word_valid with no word_ready has no effect; the upstream source holds word_in.

Optional Feature:
- Macro: ALPHA_DATA_EMULATOR_PARITY_EN.
- Defined:
  - Each data word, but not the header, is followed by one even-parity bit: the XOR of its 16 bits.
  - word_ready moves to the parity-bit cycle.
  - Frame length becomes 16 + 17*WORDS_PER_FRAME + GAP_CYCLES.
- Undefined: no parity bit; timing as above.

Decomposition:
- Shared alpha package/include holds:
  - ALPHA_WORD_WIDTH=16.
  - Default header constant ALPHA_HEADER=16'hA1FA, shared with alpha_readout.
  - State encodings localparams IDLE/HEADER/DATA/GAP.
- One sub-module is natural: alpha_word_serializer, a 16-bit load/shift register with bit counter and last_bit strobe. The top level keeps the FSM, handshake and counters.

Test Plan:
- Reset then start, with WORDS_PER_FRAME=2, GAP_CYCLES=4, words 16'h1234 and 16'hBEEF always valid:
  - data_a carries 1010000111111010 0001001000110100 1011111011101111 then 0000.
  - frame_done pulses at cycle 52 after start.
  - words_sent=2, underflow=0.
- word_valid held low for the second word: that word is sent as 16'h0000, underflow=1 until the next accepted start, and frame length is unchanged.
- start pulsed again at cycle 10 of a frame and in the frame_done cycle: ignored; exactly one frame is emitted and busy stays continuous.
- Reset asserted at bit 5 of the first data word: next edge data_a=0, busy=0, no frame_done; a fresh start then produces a full correct frame.
- Loopback into alpha_readout with defaults and incrementing words 16'h0000..16'h0007: header is detected and data_word sequence matches with no gaps.
- With ALPHA_DATA_EMULATOR_PARITY_EN, word 16'h0001: parity bit 1 follows the word; for 16'h0003 the parity bit is 0; frame length is 16+17*N+GAP.
